fft_peak_picker: RTL and testbench
==================================

# fft_peak_picker

Consumes the AXI-stream output frame of the 4096-point FFT core and reports the dominant frequency bin for the transcription pipeline. Per bin it computes the squared magnitude from the packed real/imaginary output word. It tracks the maximum over the searchable bins and emits one result per frame (bin index, magnitude, frame-error flag) on a valid/ready handshake. It applies backpressure to the FFT core while a result is pending.

## Interface
- N_POINTS, 4096, FFT frame length in beats; power of two.
- MIN_BIN, 1, lowest searched bin; excludes DC.
- MAX_BIN, 2047, highest searched bin (first half; upper half mirrors a real input).
- clk_in  input  1  system clock.
- rst_in_n  input  1  asynchronous, active-low reset.
- fft_out_data  input  16  FFT output word: [15:8] signed real, [7:0] signed imaginary.
- fft_out_valid  input  1  FFT beat valid.
- fft_out_last  input  1  last beat of FFT frame.
- fft_out_ready  output  1  beat accepted when valid && ready.
- peak_bin_out  output  12  index of strongest bin.
- peak_mag_out  output  16  squared magnitude of that bin, unsigned.
- len_err_out  output  1  frame length differed from N_POINTS.
- peak_valid_out  output  1  result valid.
- peak_ready_in  input  1  downstream accepts result.

## Operation
- Accept beat when fft_out_valid && fft_out_ready. The bin counter (12 bit) starts at 0 and increments per accepted beat.
- Stage 1 (registered): re² and im², each computed as signed 8×8 → unsigned 15 bit; tagged with bin index and end flag.
- Stage 2: mag = re² + im², 16-bit unsigned, no saturation needed (max 32768). If MIN_BIN ≤ bin ≤ MAX_BIN and mag > best_mag, update best_mag and best_bin.
- Strict greater-than: ties keep the lowest bin.
- Per frame, best_mag is initialised to 0 and best_bin to MIN_BIN. An all-zero frame reports bin MIN_BIN, mag 0.
- Frame end is the accepted beat with fft_out_last=1, or the accepted beat with counter = N_POINTS-1, whichever comes first.
- len_err is set if last arrives with counter ≠ N_POINTS-1, or if counter reaches N_POINTS-1 without last.
- On frame end, the counter returns to 0 and the drain flag is set. If the FFT core keeps sending beats of an overlong frame, they form the next frame after the stall.
- drain clears when the end beat leaves stage 2. At that moment the result registers are loaded and peak_valid_out rises.
- fft_out_ready = !drain && !peak_valid_out, so ingest stalls from end-of-frame until the result is consumed.
- Result cleared when peak_valid_out && peak_ready_in. Outputs hold stable while valid && !ready.

## Timing
- Reset (async assert, sync release) values:
  - fft_out_ready=1, peak_valid_out=0, peak_bin_out=0, peak_mag_out=0, len_err_out=0.
  - Counter, drain, pipeline valids and best registers are cleared.
- Reset mid-frame discards the partial frame, with no result emitted.
- End beat accepted in cycle t:
  - fft_out_ready=0 from t+1.
  - peak_valid_out=1 from t+2.
  - If peak_ready_in=1 at t+2, fft_out_ready=1 again at t+3.
- Throughput is one beat per cycle within a frame. The frame-to-frame gap is at least 2 cycles plus the downstream wait.
- fft_out_ready depends only on registers (no combinational path from peak_ready_in).

## Configuration
- FFT_PEAK_THRESH_EN defined:
  - Adds input thresh_in (16 bit) and output note_on_out (1 bit).
  - note_on_out = (best_mag ≥ thresh_in), sampled when the result loads and held with the result.
  - note_on_out resets to 0.
- Undefined: neither port exists, and the remaining behaviour is identical.

## Test plan
- Full 4096-beat frame, all zero except bin 440 = {8'd10, 8'd-5}, last on beat 4095, peak_ready_in=1 -> result bin 440, mag 125, len_err 0, valid exactly 2 cycles after last.
- Bins 100 and 300 both {8'd-128, 8'd-128} -> bin 100, mag 32768 (tie keeps lower; signed squaring correct).
- Bin 0 = {8'd127,0} and bin 3000 = {8'd127,0}, others zero -> bin MIN_BIN=1, mag 0 (DC and upper half ignored).
- peak_ready_in held 0 for 50 cycles after result -> fft_out_ready stays 0, outputs stable. Release -> ready returns next cycle, and the next frame's result is correct.
- last asserted on beat 99 -> result covers beats 0..99 with len_err_out=1. No last on a 4096-beat frame -> frame ends at beat 4095 with len_err_out=1.
- Assert rst_in_n low at beat 2000 -> outputs go to reset values immediately. The next full frame reports correctly. With FFT_PEAK_THRESH_EN: thresh_in=125 at mag 125 -> note_on_out=1. thresh_in=126 -> note_on_out=0.

Source files
------------

// File: rtl/fft_peak_picker.sv
// rtl/fft_peak_picker.sv - per-frame dominant FFT bin search with result handshake
// Optional feature macro: FFT_PEAK_THRESH_EN (adds thresh_in / note_on_out).
module fft_peak_picker #(
    parameter int N_POINTS = 4096,
    parameter int MIN_BIN  = 1,
    parameter int MAX_BIN  = 2047
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic [15:0] fft_out_data,
    input  logic        fft_out_valid,
    input  logic        fft_out_last,
    output logic        fft_out_ready,
    output logic [11:0] peak_bin_out,
    output logic [15:0] peak_mag_out,
    output logic        len_err_out,
    output logic        peak_valid_out,
`ifdef FFT_PEAK_THRESH_EN
    input  logic [15:0] thresh_in,
    output logic        note_on_out,
`endif
    input  logic        peak_ready_in
);

    localparam logic [11:0] LAST_B = 12'(N_POINTS - 1);
    localparam logic [11:0] MIN_B  = 12'(MIN_BIN);
    localparam logic [11:0] MAX_B  = 12'(MAX_BIN);

    logic [11:0] cnt_q, cnt_d;
    logic        drain_q, drain_d;

    logic        s1_valid_q, s1_valid_d;
    logic [14:0] s1_re2_q, s1_re2_d;
    logic [14:0] s1_im2_q, s1_im2_d;
    logic [11:0] s1_bin_q, s1_bin_d;
    logic        s1_end_q, s1_end_d;
    logic        s1_err_q, s1_err_d;

    logic [15:0] best_mag_q, best_mag_d;
    logic [11:0] best_bin_q, best_bin_d;

    logic [11:0] res_bin_q, res_bin_d;
    logic [15:0] res_mag_q, res_mag_d;
    logic        res_err_q, res_err_d;
    logic        res_valid_q, res_valid_d;
`ifdef FFT_PEAK_THRESH_EN
    logic        res_note_q, res_note_d;
`endif

    logic               accept;
    logic               at_last_b;
    logic               frame_end;
    logic signed [7:0]  re_s, im_s;
    logic signed [15:0] re_sq, im_sq;
    logic [15:0]        mag;
    logic               in_range;
    logic               upd;
    logic               load;
    logic [15:0]        cand_mag;
    logic [11:0]        cand_bin;

    // Ready is purely registered so downstream ready never ripples back upstream.
    assign fft_out_ready = !drain_q && !res_valid_q;

    always_comb begin
        accept    = fft_out_valid && fft_out_ready;
        at_last_b = (cnt_q == LAST_B);
        frame_end = accept && (fft_out_last || at_last_b);

        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = frame_end ? 12'd0 : cnt_q + 12'd1;
        end

        re_s  = fft_out_data[15:8];
        im_s  = fft_out_data[7:0];
        re_sq = 16'(re_s) * 16'(re_s);
        im_sq = 16'(im_s) * 16'(im_s);

        s1_valid_d = accept;
        s1_re2_d   = re_sq[14:0];
        s1_im2_d   = im_sq[14:0];
        s1_bin_d   = cnt_q;
        s1_end_d   = frame_end;
        // Clean end only when last coincides with the final beat index.
        s1_err_d   = fft_out_last != at_last_b;

        mag      = 16'(s1_re2_q) + 16'(s1_im2_q);
        in_range = (s1_bin_q >= MIN_B) && (s1_bin_q <= MAX_B);
        upd      = s1_valid_q && in_range && (mag > best_mag_q);
        cand_mag = upd ? mag : best_mag_q;
        cand_bin = upd ? s1_bin_q : best_bin_q;
        load     = s1_valid_q && s1_end_q;

        best_mag_d = cand_mag;
        best_bin_d = cand_bin;
        drain_d    = drain_q;
        if (frame_end) begin
            drain_d = 1'b1;
        end else if (load) begin
            drain_d = 1'b0;
        end

        res_bin_d   = res_bin_q;
        res_mag_d   = res_mag_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
`ifdef FFT_PEAK_THRESH_EN
        res_note_d  = res_note_q;
`endif
        if (res_valid_q && peak_ready_in) begin
            res_valid_d = 1'b0;
        end
        if (load) begin
            res_bin_d   = cand_bin;
            res_mag_d   = cand_mag;
            res_err_d   = s1_err_q;
            res_valid_d = 1'b1;
            best_mag_d  = 16'd0;
            best_bin_d  = MIN_B;
`ifdef FFT_PEAK_THRESH_EN
            res_note_d  = (cand_mag >= thresh_in);
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_re2_q    <= '0;
            s1_im2_q    <= '0;
            s1_bin_q    <= '0;
            s1_end_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            best_mag_q  <= '0;
            best_bin_q  <= MIN_B;
            res_bin_q   <= '0;
            res_mag_q   <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef FFT_PEAK_THRESH_EN
            res_note_q  <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            s1_valid_q  <= s1_valid_d;
            s1_re2_q    <= s1_re2_d;
            s1_im2_q    <= s1_im2_d;
            s1_bin_q    <= s1_bin_d;
            s1_end_q    <= s1_end_d;
            s1_err_q    <= s1_err_d;
            best_mag_q  <= best_mag_d;
            best_bin_q  <= best_bin_d;
            res_bin_q   <= res_bin_d;
            res_mag_q   <= res_mag_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
`ifdef FFT_PEAK_THRESH_EN
            res_note_q  <= res_note_d;
`endif
        end
    end

    assign peak_bin_out   = res_bin_q;
    assign peak_mag_out   = res_mag_q;
    assign len_err_out    = res_err_q;
    assign peak_valid_out = res_valid_q;
`ifdef FFT_PEAK_THRESH_EN
    assign note_on_out    = res_note_q;
`endif

endmodule

// File: tb/tb_fft_peak_picker.sv
// tb/tb_fft_peak_picker.sv - scoreboard bench for fft_peak_picker
// Expected results are pushed by the stimulus and popped by a monitor on each result handshake.
module tb_fft_peak_picker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] fft_out_data;
    logic        fft_out_valid;
    logic        fft_out_last;
    logic        fft_out_ready;
    logic [11:0] peak_bin_out;
    logic [15:0] peak_mag_out;
    logic        len_err_out;
    logic        peak_valid_out;
    logic        peak_ready_in;
    logic [15:0] thresh;
`ifdef FFT_PEAK_THRESH_EN
    logic        note_on_out;
`endif

    fft_peak_picker dut (
        .clk_in         (clk),
        .rst_in_n       (rst_n),
        .fft_out_data   (fft_out_data),
        .fft_out_valid  (fft_out_valid),
        .fft_out_last   (fft_out_last),
        .fft_out_ready  (fft_out_ready),
        .peak_bin_out   (peak_bin_out),
        .peak_mag_out   (peak_mag_out),
        .len_err_out    (len_err_out),
        .peak_valid_out (peak_valid_out),
`ifdef FFT_PEAK_THRESH_EN
        .thresh_in      (thresh),
        .note_on_out    (note_on_out),
`endif
        .peak_ready_in  (peak_ready_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bin;
        logic [15:0] mag;
        logic        err;
        logic        note;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          fails  = 0;
    logic [15:0] frame_mem[4096];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int bin, input int mag, input bit err, input bit note);
        exp_t e;
        e.bin  = 12'(bin);
        e.mag  = 16'(mag);
        e.err  = err;
        e.note = note;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison set per accepted result
    always @(negedge clk) begin
        if (rst_n && peak_valid_out && peak_ready_in) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(peak_valid_out), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("peak_bin", 32'(peak_bin_out), 32'(e.bin));
                chk("peak_mag", 32'(peak_mag_out), 32'(e.mag));
                chk("len_err", 32'(len_err_out), 32'(e.err));
`ifdef FFT_PEAK_THRESH_EN
                chk("note_on", 32'(note_on_out), 32'(e.note));
`endif
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) frame_mem[i] = 16'h0000;
    endtask

    task automatic send_beat(input logic [15:0] d, input bit lst);
        int w = 0;
        @(negedge clk);
        fft_out_data  = d;
        fft_out_valid = 1'b1;
        fft_out_last  = lst;
        while (!fft_out_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("beat_ready_timeout", 32'(fft_out_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic send_frame(input int nbeats, input int last_idx);
        for (int i = 0; i < nbeats; i++) send_beat(frame_mem[i], i == last_idx);
    endtask

    task automatic idle();
        @(negedge clk);
        fft_out_valid = 1'b0;
        fft_out_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("result_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        fft_out_data  = '0;
        fft_out_valid = 1'b0;
        fft_out_last  = 1'b0;
        peak_ready_in = 1'b1;
        thresh        = 16'd125;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(fft_out_ready), 32'd1);
        chk("rst_valid", 32'(peak_valid_out), 32'd0);
        chk("rst_bin", 32'(peak_bin_out), 32'd0);
        chk("rst_mag", 32'(peak_mag_out), 32'd0);
        chk("rst_err", 32'(len_err_out), 32'd0);
        rst_n = 1'b1;

        // Single tone at bin 440, exact latency checks
        frame_mem[440] = 16'h0AFB;
        push_exp(440, 125, 1'b0, 1'b1);
        send_frame(4096, 4095);
        idle();
        chk("t1_ready_low", 32'(fft_out_ready), 32'd0);
        chk("t1_valid_low", 32'(peak_valid_out), 32'd0);
        @(negedge clk);
        chk("t2_valid_high", 32'(peak_valid_out), 32'd1);
        chk("t2_ready_low", 32'(fft_out_ready), 32'd0);
        @(negedge clk);
        chk("t3_ready_high", 32'(fft_out_ready), 32'd1);
        chk("t3_valid_low", 32'(peak_valid_out), 32'd0);
        wait_drain();
        thresh = 16'd126;

        // Tie at full-scale negative: lower bin wins
        clear_mem();
        frame_mem[100] = 16'h8080;
        frame_mem[300] = 16'h8080;
        push_exp(100, 32768, 1'b0, 1'b1);
        send_frame(4096, 4095);
        idle();
        wait_drain();

        // DC and upper half ignored
        clear_mem();
        frame_mem[0]    = 16'h7F00;
        frame_mem[2048] = 16'h7F00;
        frame_mem[3000] = 16'h7F00;
        push_exp(1, 0, 1'b0, 1'b0);
        send_frame(4096, 4095);
        idle();
        wait_drain();

        // Downstream stall for 50 cycles
        clear_mem();
        frame_mem[1000] = 16'hEC0F;
        peak_ready_in = 1'b0;
        push_exp(1000, 625, 1'b0, 1'b1);
        send_frame(4096, 4095);
        idle();
        begin
            int w = 0;
            while (!peak_valid_out && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk("stall_valid_seen", 32'(peak_valid_out), 32'd1);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("stall_ready", 32'(fft_out_ready), 32'd0);
            chk("stall_valid", 32'(peak_valid_out), 32'd1);
            chk("stall_bin", 32'(peak_bin_out), 32'd1000);
            chk("stall_mag", 32'(peak_mag_out), 32'd625);
        end
        @(posedge clk);
        #1 peak_ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_ready", 32'(fft_out_ready), 32'd1);
        wait_drain();

        // MAX_BIN boundary is searched
        clear_mem();
        frame_mem[2047] = 16'h00F9;
        push_exp(2047, 49, 1'b0, 1'b0);
        send_frame(4096, 4095);
        idle();
        wait_drain();

        // Short frame: last on beat 99
        clear_mem();
        frame_mem[50]  = 16'h0AFB;
        frame_mem[200] = 16'h7F00;
        push_exp(50, 125, 1'b1, 1'b0);
        send_frame(100, 99);
        idle();
        wait_drain();

        // Missing last: frame closes at beat 4095
        clear_mem();
        frame_mem[1] = 16'hFF00;
        push_exp(1, 1, 1'b1, 1'b0);
        send_frame(4096, -1);
        idle();
        wait_drain();

        // Reset in the middle of a frame
        clear_mem();
        frame_mem[10] = 16'h7F7F;
        send_frame(2000, -1);
        @(negedge clk);
        fft_out_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(fft_out_ready), 32'd1);
        chk("mid_rst_valid", 32'(peak_valid_out), 32'd0);
        chk("mid_rst_bin", 32'(peak_bin_out), 32'd0);
        chk("mid_rst_mag", 32'(peak_mag_out), 32'd0);
        chk("mid_rst_err", 32'(len_err_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_no_result", 32'(peak_valid_out), 32'd0);

        clear_mem();
        frame_mem[2000] = 16'hCECE;
        push_exp(2000, 5000, 1'b0, 1'b1);
        send_frame(4096, 4095);
        idle();
        wait_drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
